ex_muldiv_unit: RTL and testbench

Multi-cycle execute unit that runs beside the single-cycle ALU path in the EX stage. It executes MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI and MTLO against architectural HI/LO registers. Its operand forwarding generalises to N_FWD sources. While an iterative operation is in flight, it raises a stall so the hazard logic can hold IF/ID/EX.

---
 rtl/ex_pkg.sv | 24 ++
 rtl/muldiv_core.sv | 140 ++++++++++++++
 rtl/ex_muldiv_unit.sv | 150 +++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit.
//   - op codes presented on i_EX_op (OP_NONE..OP_MTLO)
//   - FSM state encoding (ST_IDLE / ST_BUSY)
//   - forwarding select value that picks the register-file operand
package ex_pkg;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam int unsigned FWD_REG = 0;

endpackage

// File: rtl/muldiv_core.sv
// Iterative multiply/divide datapath, one bit per cycle.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   start_i        : latch operands and begin (only asserted while idle)
//   flush_i        : abandon the running operation
//   is_div_i       : 1 = divide, 0 = multiply
//   is_signed_i    : two's-complement operands
//   a_i, b_i       : multiplicand/multiplier or dividend/divisor
//   done_o         : last iteration; hi_o/lo_o hold the final result this cycle
//   hi_o, lo_o     : sign-corrected result (product high/low or remainder/quotient)
module muldiv_core #(
  parameter int unsigned NB_DATA = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               flush_i,
  input  logic               is_div_i,
  input  logic               is_signed_i,
  input  logic [NB_DATA-1:0] a_i,
  input  logic [NB_DATA-1:0] b_i,
  output logic               done_o,
  output logic [NB_DATA-1:0] hi_o,
  output logic [NB_DATA-1:0] lo_o
);

  localparam int unsigned NB_CNT = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;
  localparam int unsigned NB_ACC = 2 * NB_DATA;

  logic [NB_ACC-1:0]  acc_q, acc_d;
  logic [NB_DATA-1:0] opnd_q, opnd_d;
  logic [NB_CNT-1:0]  cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;      // product / quotient negative
  logic               rneg_q, rneg_d;    // remainder negative (follows dividend)
  logic               div0_q, div0_d;

  logic               a_neg, b_neg;
  logic [NB_DATA-1:0] a_mag, b_mag;
  logic [NB_DATA:0]   mul_sum;
  logic [NB_DATA:0]   rem_sh;
  logic [NB_DATA:0]   div_diff;
  logic               div_ge;
  logic [NB_ACC-1:0]  step;
  logic [NB_ACC-1:0]  prod;
  logic [NB_DATA-1:0] quo, rem;

  assign a_neg = is_signed_i & a_i[NB_DATA-1];
  assign b_neg = is_signed_i & b_i[NB_DATA-1];
  assign a_mag = a_neg ? (~a_i + NB_DATA'(1)) : a_i;
  assign b_mag = b_neg ? (~b_i + NB_DATA'(1)) : b_i;

  // One iteration of the selected algorithm on the current accumulator.
  always_comb begin
    // Multiply: add multiplicand into upper half when LSB of multiplier is set, shift right.
    mul_sum  = acc_q[0] ? ({1'b0, acc_q[NB_ACC-1:NB_DATA]} + {1'b0, opnd_q})
                        : {1'b0, acc_q[NB_ACC-1:NB_DATA]};
    // Divide: shift next dividend bit into the partial remainder and trial-subtract.
    rem_sh   = acc_q[NB_ACC-1:NB_DATA-1];
    div_diff = rem_sh - {1'b0, opnd_q};
    div_ge   = (rem_sh >= {1'b0, opnd_q});
    if (is_div_q) begin
      step = {(div_ge ? div_diff[NB_DATA-1:0] : rem_sh[NB_DATA-1:0]),
              acc_q[NB_DATA-2:0], div_ge};
    end else begin
      step = {mul_sum, acc_q[NB_DATA-1:1]};
    end
  end

  // Sign fix-up applied to the final iteration's result.
  always_comb begin
    prod = neg_q ? (~step + NB_ACC'(1)) : step;
    quo  = step[NB_DATA-1:0];
    rem  = step[NB_ACC-1:NB_DATA];
    if (is_div_q) begin
      // Divide by zero leaves the dividend in the remainder naturally; force quotient to all ones.
      lo_o = div0_q ? '1 : (neg_q ? (~quo + NB_DATA'(1)) : quo);
      hi_o = rneg_q ? (~rem + NB_DATA'(1)) : rem;
    end else begin
      lo_o = prod[NB_DATA-1:0];
      hi_o = prod[NB_ACC-1:NB_DATA];
    end
  end

  assign done_o = busy_q & (cnt_q == '0);

  always_comb begin
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    div0_d   = div0_q;
    if (flush_i) begin
      busy_d = 1'b0;
      cnt_d  = '0;
    end else if (start_i) begin
      acc_d    = {{NB_DATA{1'b0}}, (is_div_i ? a_mag : b_mag)};
      opnd_d   = is_div_i ? b_mag : a_mag;
      cnt_d    = NB_CNT'(NB_DATA - 1);
      busy_d   = 1'b1;
      is_div_d = is_div_i;
      neg_d    = a_neg ^ b_neg;
      rneg_d   = a_neg;
      div0_d   = is_div_i & (b_i == '0);
    end else if (busy_q) begin
      acc_d = step;
      if (cnt_q == '0) begin
        busy_d = 1'b0;
      end else begin
        cnt_d = cnt_q - NB_CNT'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q    <= '0;
      opnd_q   <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      div0_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      div0_q   <= div0_d;
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage multi-cycle unit: MULT/MULTU/DIV/DIVU plus HI/LO moves.
//   i_clock, i_reset            : clock, synchronous active-high reset
//   i_EX_valid, i_EX_op         : instruction presented in EX
//   i_EX_data_a/b               : register-file operands
//   i_EX_fwd_data, i_EX_fwd_a/b : packed forwarding channels and per-operand selects
//   i_EX_flush                  : abort in-flight op, drop same-cycle writes/accepts
//   o_EX_result(_valid)         : MFHI/MFLO readout
//   o_EX_stall, o_EX_busy       : hazard hold request, iteration in progress
//   o_EX_hi, o_EX_lo            : architectural HI/LO
module ex_muldiv_unit #(
  parameter int unsigned NB_DATA = 32,
  parameter int unsigned N_FWD   = 2,
  parameter int unsigned NB_SEL  = 2,
  parameter int unsigned NB_OP   = 4
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_EX_valid,
  input  logic [NB_OP-1:0]         i_EX_op,
  input  logic [NB_DATA-1:0]       i_EX_data_a,
  input  logic [NB_DATA-1:0]       i_EX_data_b,
  input  logic [N_FWD*NB_DATA-1:0] i_EX_fwd_data,
  input  logic [NB_SEL-1:0]        i_EX_fwd_a,
  input  logic [NB_SEL-1:0]        i_EX_fwd_b,
  input  logic                     i_EX_flush,
  output logic [NB_DATA-1:0]       o_EX_result,
  output logic                     o_EX_result_valid,
  output logic                     o_EX_stall,
  output logic                     o_EX_busy,
  output logic [NB_DATA-1:0]       o_EX_hi,
  output logic [NB_DATA-1:0]       o_EX_lo
);

  import ex_pkg::*;

  state_e             state_q, state_d;
  logic [NB_DATA-1:0] hi_q, hi_d;
  logic [NB_DATA-1:0] lo_q, lo_d;

  logic [NB_DATA-1:0] fwd_ch [N_FWD];
  logic [NB_DATA-1:0] opnd_a, opnd_b;

  logic is_mult, is_multu, is_div, is_divu, is_mfhi, is_mflo, is_mthi, is_mtlo;
  logic is_md, is_none, idle, accept, serviced;
  logic core_done;
  logic [NB_DATA-1:0] core_hi, core_lo;

  // Unpack forwarding channels.
  for (genvar k = 0; k < N_FWD; k++) begin : g_fwd
    assign fwd_ch[k] = i_EX_fwd_data[k*NB_DATA +: NB_DATA];
  end

  // Select k in 1..N_FWD picks channel k-1; FWD_REG and out-of-range selects keep the register.
  always_comb begin
    opnd_a = i_EX_data_a;
    opnd_b = i_EX_data_b;
    for (int k = 1; k <= int'(N_FWD); k++) begin
      if (i_EX_fwd_a == NB_SEL'(k)) opnd_a = fwd_ch[k-1];
      if (i_EX_fwd_b == NB_SEL'(k)) opnd_b = fwd_ch[k-1];
    end
  end

  // Invalid instructions decode as OP_NONE.
  assign is_mult  = i_EX_valid & (i_EX_op == NB_OP'(OP_MULT));
  assign is_multu = i_EX_valid & (i_EX_op == NB_OP'(OP_MULTU));
  assign is_div   = i_EX_valid & (i_EX_op == NB_OP'(OP_DIV));
  assign is_divu  = i_EX_valid & (i_EX_op == NB_OP'(OP_DIVU));
  assign is_mfhi  = i_EX_valid & (i_EX_op == NB_OP'(OP_MFHI));
  assign is_mflo  = i_EX_valid & (i_EX_op == NB_OP'(OP_MFLO));
  assign is_mthi  = i_EX_valid & (i_EX_op == NB_OP'(OP_MTHI));
  assign is_mtlo  = i_EX_valid & (i_EX_op == NB_OP'(OP_MTLO));
  assign is_none  = ~i_EX_valid | (i_EX_op == NB_OP'(OP_NONE));
  assign is_md    = is_mult | is_multu | is_div | is_divu;

  assign idle     = (state_q == ST_IDLE);
  assign accept   = is_md & idle & ~i_EX_flush;
  assign serviced = idle & ~i_EX_flush;

  muldiv_core #(
    .NB_DATA (NB_DATA)
  ) u_core (
    .clk_i       (i_clock),
    .rst_i       (i_reset),
    .start_i     (accept),
    .flush_i     (i_EX_flush),
    .is_div_i    (is_div | is_divu),
    .is_signed_i (is_mult | is_div),
    .a_i         (opnd_a),
    .b_i         (opnd_b),
    .done_o      (core_done),
    .hi_o        (core_hi),
    .lo_o        (core_lo)
  );

  // FSM: state register.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = ST_BUSY;
      ST_BUSY: if (i_EX_flush || core_done) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs. Stall only depends on op/valid and state, never on operands.
  always_comb begin
    o_EX_busy         = (state_q == ST_BUSY);
    o_EX_stall        = (state_q == ST_BUSY) & ~is_none;
    o_EX_result_valid = idle & (is_mfhi | is_mflo);
    o_EX_result       = '0;
    if (idle && is_mfhi) o_EX_result = hi_q;
    if (idle && is_mflo) o_EX_result = lo_q;
  end

  // HI/LO update: completion and MTHI/MTLO cannot coincide since moves stall while busy.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (core_done && !i_EX_flush) begin
      hi_d = core_hi;
      lo_d = core_lo;
    end else if (serviced) begin
      if (is_mthi) hi_d = opnd_a;
      if (is_mtlo) lo_d = opnd_a;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign o_EX_hi = hi_q;
  assign o_EX_lo = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
module tb_ex_muldiv_unit;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [3:0]  op;
  logic [31:0] data_a, data_b;
  logic [63:0] fwd_data;
  logic [1:0]  fwd_a, fwd_b;
  logic        flush;
  logic [31:0] result, hi, lo;
  logic        result_valid, stall, busy;

  int n_tests = 0;
  int n_fail  = 0;

  ex_muldiv_unit #(
    .NB_DATA (32),
    .N_FWD   (2),
    .NB_SEL  (2),
    .NB_OP   (4)
  ) dut (
    .i_clock           (clk),
    .i_reset           (rst),
    .i_EX_valid        (valid),
    .i_EX_op           (op),
    .i_EX_data_a       (data_a),
    .i_EX_data_b       (data_b),
    .i_EX_fwd_data     (fwd_data),
    .i_EX_fwd_a        (fwd_a),
    .i_EX_fwd_b        (fwd_b),
    .i_EX_flush        (flush),
    .o_EX_result       (result),
    .o_EX_result_valid (result_valid),
    .o_EX_stall        (stall),
    .o_EX_busy         (busy),
    .o_EX_hi           (hi),
    .o_EX_lo           (lo)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    valid  = 1'b1;
    op     = o;
    data_a = a;
    data_b = b;
  endtask

  task automatic idle_inputs();
    valid = 1'b0;
    op    = OP_NONE;
  endtask

  // Count BUSY cycles until the unit goes idle, bounded.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 200) begin
      n++;
      tick();
    end
  endtask

  // Issue a mul/div from the register operands and run it to completion.
  task automatic run_md(input string tag, input logic [3:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    int n;
    present(o, a, b);
    #1;
    check_eq({tag, "_nostall"}, {31'b0, stall}, 32'd0);
    tick();
    idle_inputs();
    wait_idle(n);
    check_eq({tag, "_cycles"}, n, 32'd32);
    check_eq({tag, "_hi"}, hi, exp_hi);
    check_eq({tag, "_lo"}, lo, exp_lo);
  endtask

  initial begin
    int n;
    rst      = 1'b1;
    valid    = 1'b0;
    op       = OP_NONE;
    data_a   = '0;
    data_b   = '0;
    fwd_data = '0;
    fwd_a    = 2'd0;
    fwd_b    = 2'd0;
    flush    = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;

    // Reset state
    check_eq("rst_result", result, 32'd0);
    check_eq("rst_rvalid", {31'b0, result_valid}, 32'd0);
    check_eq("rst_stall", {31'b0, stall}, 32'd0);
    check_eq("rst_busy", {31'b0, busy}, 32'd0);
    check_eq("rst_hi", hi, 32'd0);
    check_eq("rst_lo", lo, 32'd0);

    // MULTU 0xFFFFFFFF x 2 followed directly by MFLO that must stall 32 cycles
    present(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
    tick();
    check_eq("multu_busy", {31'b0, busy}, 32'd1);
    present(OP_MFLO, 32'd0, 32'd0);
    n = 0;
    #1;
    while (stall && n < 200) begin
      n++;
      tick();
    end
    check_eq("mflo_stall_cycles", n, 32'd32);
    check_eq("mflo_result", result, 32'hFFFF_FFFE);
    check_eq("mflo_rvalid", {31'b0, result_valid}, 32'd1);
    check_eq("multu_hi", hi, 32'h0000_0001);
    tick();
    idle_inputs();
    #1;
    check_eq("none_rvalid", {31'b0, result_valid}, 32'd0);

    // Signed multiply
    run_md("mult_m3x5", OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_md("mult_minsq", OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);

    // Divides
    run_md("div_m7d2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    present(OP_MFHI, 32'd0, 32'd0);
    #1;
    check_eq("mfhi_result", result, 32'hFFFF_FFFF);
    check_eq("mfhi_rvalid", {31'b0, result_valid}, 32'd1);
    idle_inputs();
    run_md("divu_7d0", OP_DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF);
    run_md("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
    run_md("div_m7d0", OP_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);

    // Forwarding: ch0 = 5, ch1 = 9, register a = 1
    fwd_data = {32'd9, 32'd5};
    present(OP_MTHI, 32'd1, 32'd0);
    fwd_a = 2'd2;
    tick();
    check_eq("fwd_ch1_hi", hi, 32'd9);
    fwd_a = 2'd3;
    tick();
    check_eq("fwd_oor_hi", hi, 32'd1);
    present(OP_MTLO, 32'd1, 32'd0);
    fwd_a = 2'd1;
    tick();
    check_eq("fwd_ch0_lo", lo, 32'd5);
    // Forwarded operand b into a divide: 100 / ch1 (9) = 11 r 1
    fwd_a = 2'd0;
    fwd_b = 2'd2;
    run_md("fwd_b_divu", OP_DIVU, 32'd100, 32'd0, 32'd1, 32'd11);
    fwd_b = 2'd0;

    // Flush at BUSY cycle 10 of a DIVU
    present(OP_MTHI, 32'h55, 32'd0);
    tick();
    present(OP_MTLO, 32'h55, 32'd0);
    tick();
    present(OP_DIVU, 32'd100, 32'd3);
    tick();
    idle_inputs();
    for (int i = 0; i < 9; i++) tick();
    check_eq("flush_pre_busy", {31'b0, busy}, 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_eq("flush_busy", {31'b0, busy}, 32'd0);
    check_eq("flush_hi", hi, 32'h55);
    check_eq("flush_lo", lo, 32'h55);
    for (int i = 0; i < 30; i++) tick();
    check_eq("flush_late_lo", lo, 32'h55);

    // Flush concurrent with accept and with MTHI
    present(OP_MULT, 32'd3, 32'd4);
    flush = 1'b1;
    tick();
    check_eq("flush_acc_busy", {31'b0, busy}, 32'd0);
    present(OP_MTHI, 32'd7, 32'd0);
    tick();
    flush = 1'b0;
    idle_inputs();
    check_eq("flush_mthi_hi", hi, 32'h55);

    // Reset mid-MULT
    present(OP_MULT, 32'd3, 32'd4);
    tick();
    idle_inputs();
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("midrst_busy", {31'b0, busy}, 32'd0);
    check_eq("midrst_hi", hi, 32'd0);
    check_eq("midrst_lo", lo, 32'd0);
    check_eq("midrst_stall", {31'b0, stall}, 32'd0);
    check_eq("midrst_result", result, 32'd0);
    run_md("multu_3x4", OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12);

    // Back-to-back: DIVU 13/4 held behind a running MULTU
    present(OP_MULTU, 32'd6, 32'd7);
    tick();
    present(OP_DIVU, 32'd13, 32'd4);
    n = 0;
    #1;
    while (stall && n < 200) begin
      n++;
      tick();
    end
    check_eq("b2b_stall_cycles", n, 32'd32);
    check_eq("b2b_first_lo", lo, 32'd42);
    tick();
    idle_inputs();
    check_eq("b2b_second_busy", {31'b0, busy}, 32'd1);
    wait_idle(n);
    check_eq("b2b_cycles", n, 32'd32);
    check_eq("b2b_hi", hi, 32'd1);
    check_eq("b2b_lo", lo, 32'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
